// File: rtl/rand_board_fill.sv
`default_nettype none
// ============================================================================
//  Module      : rand_board_fill
//  Description : Fills a square board with pseudo-random colour codes, one
//                cell per clock, in row-major order. Colours come from a
//                16-bit Galois LFSR reduced modulo the requested colour count.
//  Revision    : 1.0 - initial release
// ============================================================================
module rand_board_fill (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        NEW_BOARD,
  input  logic [15:0] SEED,
  input  logic [4:0]  SIZE,
  input  logic [3:0]  COLOR_NUM,
  output logic        CELL_WE,
  output logic [4:0]  CELL_ROW,
  output logic [4:0]  CELL_COL,
  output logic [2:0]  CELL_COLOR,
  output logic        BUSY,
  output logic        READY
);

  // LFSR feedback mask and the substitute seed used when SEED is zero
  localparam logic [15:0] c_lfsr_taps   = 16'hB400;
  localparam logic [15:0] c_lfsr_default = 16'hACE1;

  // Legal ranges for the latched board parameters
  localparam logic [4:0] c_size_min  = 5'd2;
  localparam logic [4:0] c_size_max  = 5'd26;
  localparam logic [3:0] c_color_min = 4'd2;
  localparam logic [3:0] c_color_max = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_nb_q;        // previous NEW_BOARD for edge detection
  logic [15:0] r_lfsr;
  logic [4:0]  r_size;        // clamped board edge length
  logic [3:0]  r_ncol;        // clamped colour count
  logic [4:0]  r_row;
  logic [4:0]  r_col;
  logic [2:0]  r_color_hold;  // colour of the most recent write

  logic        w_accept;
  logic        w_last_cell;
  logic [15:0] w_seed_load;
  logic [15:0] w_lfsr_next;
  logic [4:0]  w_size_clamp;
  logic [3:0]  w_ncol_clamp;
  logic [2:0]  w_color;

  // Small modulo by repeated subtraction: v <= 7 and n >= 2, so three
  // conditional subtractions always reach a remainder below n.
  function automatic logic [2:0] color_mod(input logic [2:0] v, input logic [3:0] n);
    logic [3:0] r;
    r = {1'b0, v};
    for (int k = 0; k < 3; k++) begin
      if (r >= n) begin
        r = r - n;
      end
    end
    return r[2:0];
  endfunction

  // A rising request is only honoured when no fill is in progress
  assign w_accept = NEW_BOARD & ~r_nb_q & (r_state != ST_FILL);

  assign w_seed_load = (SEED == 16'h0000) ? c_lfsr_default : SEED;

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);

  assign w_size_clamp = (SIZE < c_size_min) ? c_size_min :
                        (SIZE > c_size_max) ? c_size_max : SIZE;

  assign w_ncol_clamp = (COLOR_NUM < c_color_min) ? c_color_min :
                        (COLOR_NUM > c_color_max) ? c_color_max : COLOR_NUM;

  assign w_last_cell = (r_row == (r_size - 5'd1)) && (r_col == (r_size - 5'd1));

  assign w_color = color_mod(r_lfsr[2:0], r_ncol);

  // State register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start on an accepted request, finish after the last cell
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_last_cell) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_next = ST_FILL;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request history, parameter latch, LFSR and scan position
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_nb_q       <= 1'b1;
      r_lfsr       <= c_lfsr_default;
      r_size       <= c_size_min;
      r_ncol       <= c_color_min;
      r_row        <= 5'd0;
      r_col        <= 5'd0;
      r_color_hold <= 3'd0;
    end else begin
      r_nb_q <= NEW_BOARD;
      if (w_accept) begin
        r_lfsr <= w_seed_load;
        r_size <= w_size_clamp;
        r_ncol <= w_ncol_clamp;
        r_row  <= 5'd0;
        r_col  <= 5'd0;
      end else if (r_state == ST_FILL) begin
        r_lfsr       <= w_lfsr_next;
        r_color_hold <= w_color;
        // The final cell leaves row/col parked on the last written position
        if (!w_last_cell) begin
          if (r_col == (r_size - 5'd1)) begin
            r_col <= 5'd0;
            r_row <= r_row + 5'd1;
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
      end
    end
  end

  assign CELL_WE    = (r_state == ST_FILL);
  assign BUSY       = (r_state == ST_FILL);
  assign READY      = (r_state == ST_DONE);
  assign CELL_ROW   = r_row;
  assign CELL_COL   = r_col;
  assign CELL_COLOR = (r_state == ST_FILL) ? w_color : r_color_hold;

endmodule
`default_nettype wire

// File: tb/tb_rand_board_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rand_board_fill
//  Description : Self-checking bench for rand_board_fill. A queue-based model
//                expands each accepted request into its full list of cell
//                writes; outputs are compared every cycle, plus directed
//                scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_board_fill;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        NEW_BOARD = 1'b0;
  logic [15:0] SEED = 16'h0000;
  logic [4:0]  SIZE = 5'd2;
  logic [3:0]  COLOR_NUM = 4'd2;
  logic        CELL_WE;
  logic [4:0]  CELL_ROW;
  logic [4:0]  CELL_COL;
  logic [2:0]  CELL_COLOR;
  logic        BUSY;
  logic        READY;

  rand_board_fill dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .NEW_BOARD  (NEW_BOARD),
    .SEED       (SEED),
    .SIZE       (SIZE),
    .COLOR_NUM  (COLOR_NUM),
    .CELL_WE    (CELL_WE),
    .CELL_ROW   (CELL_ROW),
    .CELL_COL   (CELL_COL),
    .CELL_COLOR (CELL_COLOR),
    .BUSY       (BUSY),
    .READY      (READY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [2:0] color;
  } cell_t;

  typedef struct {
    int    cyc;
    cell_t c;
  } wr_t;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;

  cell_t exp_q[$];
  cell_t m_last = '0;
  bit    m_ready = 1'b0;
  logic  m_prev = 1'b1;
  wr_t   wlog[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expand one request into the complete ordered list of expected writes
  function automatic void build_board(input logic [15:0] sd, input int sz_in, input int nc_in);
    logic [15:0] s;
    int sz;
    int nc;
    cell_t e;
    s  = (sd == 16'h0000) ? 16'hACE1 : sd;
    sz = (sz_in < 2) ? 2 : ((sz_in > 26) ? 26 : sz_in);
    nc = (nc_in < 2) ? 2 : ((nc_in > 8) ? 8 : nc_in);
    for (int r = 0; r < sz; r++) begin
      for (int c = 0; c < sz; c++) begin
        e.row   = 5'(r);
        e.col   = 5'(c);
        e.color = 3'(int'(s[2:0]) % nc);
        exp_q.push_back(e);
        s = lfsr_step(s);
      end
    end
  endfunction

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Reference model: one queued write retired per clock while filling
  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_prev  = 1'b1;
      m_last  = '0;
    end else begin
      if (exp_q.size() > 0) begin
        m_last = exp_q.pop_front();
        if (exp_q.size() == 0) m_ready = 1'b1;
      end else if (NEW_BOARD && !m_prev) begin
        build_board(SEED, int'(SIZE), int'(COLOR_NUM));
        m_ready = 1'b0;
      end
      m_prev = NEW_BOARD;
    end
  end

  // Per-cycle comparison against the model, and a log of observed writes
  always @(negedge CLOCK) begin
    cell_t ec;
    bit    ew;
    wr_t   w;
    ew = (exp_q.size() > 0);
    ec = ew ? exp_q[0] : m_last;
    chk("we",    int'(CELL_WE),    int'(ew));
    chk("busy",  int'(BUSY),       int'(ew));
    chk("ready", int'(READY),      int'(m_ready));
    chk("row",   int'(CELL_ROW),   int'(ec.row));
    chk("col",   int'(CELL_COL),   int'(ec.col));
    chk("color", int'(CELL_COLOR), int'(ec.color));
    if (CELL_WE) begin
      w.cyc = cyc;
      w.c   = {CELL_ROW, CELL_COL, CELL_COLOR};
      wlog.push_back(w);
    end
  end

  task automatic start(input logic [15:0] sd, input logic [4:0] sz, input logic [3:0] cn, output int t0);
    @(negedge CLOCK);
    SEED      = sd;
    SIZE      = sz;
    COLOR_NUM = cn;
    NEW_BOARD = 1'b1;
    t0        = cyc;
    @(negedge CLOCK);
    NEW_BOARD = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK);
    #1;
  endtask

  initial begin
    int t0;
    int t1;
    int base;
    int base2;
    int mx;
    int er[4];
    int ecl[4];
    int eco[4];
    er  = '{0, 0, 1, 1};
    ecl = '{0, 1, 0, 1};
    eco = '{1, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge CLOCK);
    #1;
    chk("rst_we",    int'(CELL_WE),    0);
    chk("rst_busy",  int'(BUSY),       0);
    chk("rst_ready", int'(READY),      0);
    chk("rst_row",   int'(CELL_ROW),   0);
    chk("rst_col",   int'(CELL_COL),   0);
    chk("rst_color", int'(CELL_COLOR), 0);
    #1 RESET = 1'b0;
    @(negedge CLOCK);

    // Basic fill, literal values from the LFSR sequence 0001, B400, 5A00, 2D00
    base = wlog.size();
    start(16'h0001, 5'd2, 4'd4, t0);
    wait_cyc(4);
    chk("basic_count", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wlog.size()) begin
        chk("basic_cyc",   wlog[base+i].cyc,            t0 + 1 + i);
        chk("basic_row",   int'(wlog[base+i].c.row),    er[i]);
        chk("basic_col",   int'(wlog[base+i].c.col),    ecl[i]);
        chk("basic_color", int'(wlog[base+i].c.color),  eco[i]);
      end
    end
    chk("basic_ready", int'(READY),   1);
    chk("basic_busy",  int'(BUSY),    0);
    chk("basic_we",    int'(CELL_WE), 0);

    // Zero seed substitutes 0xACE1
    base = wlog.size();
    start(16'h0000, 5'd2, 4'd8, t0);
    wait_cyc(4);
    chk("zseed_count", wlog.size() - base, 4);
    if (base < wlog.size()) begin
      chk("zseed_color", int'(wlog[base].c.color), 1);
      chk("zseed_rc",    int'({wlog[base].c.row, wlog[base].c.col}), 0);
    end

    // Clamp high: 26x26, eight colours
    base = wlog.size();
    start(16'h5A5A, 5'd30, 4'd15, t0);
    wait_cyc(676);
    chk("clamp_count", wlog.size() - base, 676);
    if (wlog.size() > base) begin
      chk("clamp_last_row", int'(wlog[wlog.size()-1].c.row), 25);
      chk("clamp_last_col", int'(wlog[wlog.size()-1].c.col), 25);
      chk("clamp_last_cyc", wlog[wlog.size()-1].cyc, t0 + 676);
    end
    mx = 0;
    for (int i = base; i < wlog.size(); i++)
      if (int'(wlog[i].c.color) > mx) mx = int'(wlog[i].c.color);
    chk("clamp_max_color", mx, 7);
    chk("clamp_ready", int'(READY), 1);

    // Clamp low: 2x2, two colours
    base = wlog.size();
    start(16'h1234, 5'd1, 4'd0, t0);
    wait_cyc(4);
    chk("clamplo_count", wlog.size() - base, 4);
    mx = 0;
    for (int i = base; i < wlog.size(); i++)
      if (int'(wlog[i].c.color) > mx) mx = int'(wlog[i].c.color);
    chk("clamplo_color_le1", int'(mx <= 1), 1);
    chk("clamplo_ready", int'(READY), 1);

    // Edge during fill is ignored, parameter changes have no effect
    base = wlog.size();
    start(16'hBEEF, 5'd3, 4'd5, t0);
    repeat (2) @(negedge CLOCK);
    NEW_BOARD = 1'b1;
    SIZE      = 5'd7;
    SEED      = 16'h0003;
    COLOR_NUM = 4'd2;
    @(negedge CLOCK);
    NEW_BOARD = 1'b0;
    wait_cyc(6);
    chk("midedge_count", wlog.size() - base, 9);
    chk("midedge_ready", int'(READY), 1);
    wait_cyc(3);
    chk("midedge_norestart", int'(BUSY), 0);

    // Edge in DONE restarts, READY drops the cycle after the edge
    base = wlog.size();
    start(16'h0042, 5'd2, 4'd3, t1);
    #1;
    chk("restart_ready", int'(READY), 0);
    chk("restart_busy",  int'(BUSY),  1);
    wait_cyc(4);
    chk("restart_count", wlog.size() - base, 4);
    chk("restart_done",  int'(READY), 1);

    // Reset in the middle of a 4x4 fill
    base = wlog.size();
    start(16'h7777, 5'd4, 4'd6, t0);
    repeat (4) @(negedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    chk("mrst_we",    int'(CELL_WE), 0);
    chk("mrst_busy",  int'(BUSY),    0);
    chk("mrst_ready", int'(READY),   0);
    chk("mrst_prior_writes", wlog.size() - base, 5);
    base2 = wlog.size();
    @(negedge CLOCK);
    #2 RESET = 1'b0;
    wait_cyc(20);
    chk("mrst_no_writes", wlog.size() - base2, 0);
    chk("mrst_ready_low", int'(READY), 0);

    // Request held high through reset release does not start a fill
    @(negedge CLOCK);
    #2 RESET = 1'b1;
    NEW_BOARD = 1'b1;
    SIZE = 5'd2;
    repeat (2) @(negedge CLOCK);
    #2 RESET = 1'b0;
    base = wlog.size();
    wait_cyc(10);
    chk("held_no_writes", wlog.size() - base, 0);
    chk("held_busy", int'(BUSY), 0);
    @(negedge CLOCK);
    NEW_BOARD = 1'b0;
    base = wlog.size();
    start(16'h0101, 5'd2, 4'd2, t0);
    wait_cyc(4);
    chk("held_then_edge", wlog.size() - base, 4);
    chk("held_ready", int'(READY), 1);

    // Randomised traffic: requests, parameter churn and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLOCK);
      NEW_BOARD = ($urandom_range(0, 5) == 0);
      SEED      = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
      SIZE      = 5'($urandom_range(0, 9));
      COLOR_NUM = 4'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 RESET = 1'b1;
        @(negedge CLOCK);
        #2 RESET = 1'b0;
      end
    end
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rand_board_fill.md
RAND_BOARD_FILL -- requirements
Module: rand_board_fill

Interface
REQ-001 SHALL have the following ports, listed as name, direction, width, meaning.
  - CLOCK, in, 1: single clock; all state updates on its rising edge.
  - RESET, in, 1: reset, asynchronous, active-high.
  - NEW_BOARD, in, 1: board request; a rising edge starts generation.
  - SEED, in, 16: LFSR seed, sampled at start.
  - SIZE, in, 5: board edge length, sampled at start.
  - COLOR_NUM, in, 4: colour count, sampled at start.
  - CELL_WE, out, 1: cell write strobe, one cell per cycle.
  - CELL_ROW, out, 5: row index of the current write.
  - CELL_COL, out, 5: column index of the current write.
  - CELL_COLOR, out, 3: colour code of the current write.
  - BUSY, out, 1: high while filling.
  - READY, out, 1: complete board has been written.

Function
REQ-002 SHALL detect a NEW_BOARD rising edge by comparing NEW_BOARD against a registered copy of it; the registered copy resets to 1.
REQ-003 SHALL implement FSM states IDLE, FILL and DONE.
REQ-004 IDLE or DONE, edge detected in cycle t: latch parameters, load LFSR, set row=col=0, clear READY, set BUSY, enter FILL in t+1.
REQ-005 Parameter clamp at latch: SIZE<2 becomes 2, SIZE>26 becomes 26; COLOR_NUM<2 becomes 2, COLOR_NUM>8 becomes 8.
REQ-006 LFSR is 16-bit Galois: next = (s>>1) XOR (s[0] ? 0xB400 : 0x0000).
REQ-007 LFSR load value is SEED, or 0xACE1 if SEED==0x0000.
REQ-008 In each FILL cycle: CELL_WE=1, CELL_ROW=row, CELL_COL=col, CELL_COLOR = s[2:0] mod latched COLOR_NUM, where s is the current LFSR state; the LFSR advances after use.
REQ-009 The first write uses the loaded seed state itself.
REQ-010 Scan order is row-major: col increments; at col==size-1, col wraps to 0 and row increments.
REQ-011 After the write of (size-1,size-1), enter DONE.
REQ-012 Write timing: exactly size*size writes, in cycles t+1 .. t+size².
REQ-013 In cycle t+size²+1: BUSY=0, READY=1, CELL_WE=0.
REQ-014 READY SHALL hold at 1 in DONE until the next accepted edge.
REQ-015 A NEW_BOARD edge during FILL SHALL be ignored: no restart, and it is not queued.
REQ-016 When CELL_WE=0, CELL_ROW, CELL_COL and CELL_COLOR SHALL hold their last values.
REQ-017 The colour modulo SHALL be purely combinational; the result is always less than the latched COLOR_NUM.
REQ-018 SEED, SIZE and COLOR_NUM changes during FILL SHALL have no effect.

Reset
REQ-019 RESET asserted SHALL immediately force:
  - state IDLE
  - CELL_WE=0, BUSY=0, READY=0
  - CELL_ROW=CELL_COL=0, CELL_COLOR=0
  - LFSR=0xACE1
  - NEW_BOARD registered copy=1
REQ-020 RESET during FILL SHALL abort generation: no further writes, READY stays 0.
REQ-021 NEW_BOARD held high through reset release SHALL NOT start generation; it must fall and rise again.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Basic fill: SEED=0x0001, SIZE=2, COLOR_NUM=4, edge at t -> writes (0,0)=1, (0,1)=0, (1,0)=0, (1,1)=0 in cycles t+1..t+4; READY=1 and BUSY=0 at t+5.
  - Zero seed: SEED=0x0000, SIZE=2, COLOR_NUM=8 -> first write (0,0)=1 (0xACE1 low bits).
  - Clamping: SIZE=30, COLOR_NUM=15 -> 676 writes, last at (25,25) in t+676, READY at t+677, all colours <=7; SIZE=1, COLOR_NUM=0 -> 4 writes, all colours in {0,1}.
  - Edge during FILL: second edge at t+3 with SIZE=3 -> 9 writes total, no restart; an edge in DONE restarts, READY drops the cycle after the edge.
  - Mid-fill reset: RESET asserted at t+5 of a SIZE=4 fill -> CELL_WE, BUSY and READY are 0 immediately; no writes afterwards.
  - Held request through reset: NEW_BOARD high before and after reset release -> no writes until NEW_BOARD goes low then high.
